regs_hazard_ctrl: RTL

- Hazard and forwarding controller that sequences register-file access for the RV32I 5-stage pipeline.
- Keeps a 3-entry shadow pipeline of in-flight destination registers (EX, MEM, WB).
- Generates decode stall (load-use), register-file read enable, and registered forwarding selects for the EX stage.
- Sits beside decode; drives the regfile's rs_rd_en and the EX operand muxes.

---
 rtl/regs_hazard_pkg.sv | 27 ++
 rtl/regs_fwd_match.sv | 44 ++++
 rtl/regs_hazard_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/regs_hazard_pkg.sv
// ============================================================================
// Module   : regs_hazard_pkg
// Purpose  : Shared types and constants for the RV32I hazard/forwarding block
// Revision : 1.0
// ============================================================================
`default_nettype none

package regs_hazard_pkg;

    localparam int SH_RD_W = 5;
    localparam logic [SH_RD_W-1:0] ZERO_REG_ADDR = '0;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic               vld;
        logic [SH_RD_W-1:0] rd;
        logic               ld;
    } sh_entry_t;

endpackage

`default_nettype wire

// File: rtl/regs_fwd_match.sv
// ============================================================================
// Module   : regs_fwd_match
// Purpose  : Compares one source operand against the EX and MEM shadow entries
// Revision : 1.0
// ============================================================================
`default_nettype none

module regs_fwd_match
    import regs_hazard_pkg::*;
(
    input  logic [SH_RD_W-1:0] src_i,
    input  logic               src_used_i,
    input  sh_entry_t          sh_ex_i,
    input  sh_entry_t          sh_mem_i,
    output fwd_sel_e           sel_o,
    output logic               load_use_o
);

    logic w_active;
    logic w_ex_hit;
    logic w_mem_hit;
    logic unused_mem_ld;

    assign w_active   = src_used_i && (src_i != ZERO_REG_ADDR);
    assign w_ex_hit   = w_active && sh_ex_i.vld  && (sh_ex_i.rd  == src_i);
    assign w_mem_hit  = w_active && sh_mem_i.vld && (sh_mem_i.rd == src_i);
    assign load_use_o = w_ex_hit && sh_ex_i.ld;

    // A load leaving MEM already has its data, so the MEM flag is irrelevant here
    assign unused_mem_ld = sh_mem_i.ld;

    // Youngest producer wins
    always_comb begin
        sel_o = FWD_RF;
        if (w_ex_hit) begin
            sel_o = FWD_EXMEM;
        end else if (w_mem_hit) begin
            sel_o = FWD_MEMWB;
        end
    end

endmodule

`default_nettype wire

// File: rtl/regs_hazard_ctrl.sv
// ============================================================================
// Module   : regs_hazard_ctrl
// Purpose  : Load-use stall and EX forwarding-select control for a 5-stage
//            RV32I pipeline. Optional stall counter: REGS_HAZARD_PERF_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module regs_hazard_ctrl
    import regs_hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int PERF_CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_rd_wr,
    input  logic                  id_is_load,
    input  logic                  pipe_hold,
    input  logic                  ex_flush,
    output logic                  rs_rd_en,
    output logic [1:0]            fwd_rs1_sel,
    output logic [1:0]            fwd_rs2_sel,
    output logic [PERF_CNT_W-1:0] stall_cnt
);

    generate
        if (REG_ADDR_W != SH_RD_W) begin : g_addr_w_chk
            $error("REG_ADDR_W must match regs_hazard_pkg::SH_RD_W");
        end
    endgenerate

    sh_entry_t sh_ex_q, sh_mem_q, sh_wb_q;
    sh_entry_t sh_ex_d, sh_mem_d;
    fwd_sel_e  fwd_rs1_q, fwd_rs2_q;
    fwd_sel_e  fwd_rs1_d, fwd_rs2_d;
    fwd_sel_e  w_sel1, w_sel2;
    logic      w_lu1, w_lu2;
    logic      w_hazard;
    logic      w_fire;
    logic      unused_sh_wb;

    regs_fwd_match u_match_rs1 (
        .src_i      (id_rs1),
        .src_used_i (id_rs1_used),
        .sh_ex_i    (sh_ex_q),
        .sh_mem_i   (sh_mem_q),
        .sel_o      (w_sel1),
        .load_use_o (w_lu1)
    );

    regs_fwd_match u_match_rs2 (
        .src_i      (id_rs2),
        .src_used_i (id_rs2_used),
        .sh_ex_i    (sh_ex_q),
        .sh_mem_i   (sh_mem_q),
        .sel_o      (w_sel2),
        .load_use_o (w_lu2)
    );

    assign w_hazard = w_lu1 || w_lu2;
    assign id_ready = !w_hazard && !pipe_hold;
    assign rs_rd_en = id_valid && id_ready;
    assign w_fire   = rs_rd_en && !ex_flush;

    always_comb begin
        sh_ex_d = '0;
        if (w_fire) begin
            sh_ex_d.vld = id_rd_wr && (id_rd != ZERO_REG_ADDR);
            sh_ex_d.rd  = id_rd;
            sh_ex_d.ld  = id_is_load;
        end
        sh_mem_d  = ex_flush ? '0 : sh_ex_q;
        fwd_rs1_d = w_fire ? w_sel1 : FWD_RF;
        fwd_rs2_d = w_fire ? w_sel2 : FWD_RF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_ex_q   <= '0;
            sh_mem_q  <= '0;
            sh_wb_q   <= '0;
            fwd_rs1_q <= FWD_RF;
            fwd_rs2_q <= FWD_RF;
        end else if (!pipe_hold) begin
            sh_wb_q   <= sh_mem_q;
            sh_mem_q  <= sh_mem_d;
            sh_ex_q   <= sh_ex_d;
            fwd_rs1_q <= fwd_rs1_d;
            fwd_rs2_q <= fwd_rs2_d;
        end
    end

    // WB producers reach the regfile before its registered read, so no consumer
    assign unused_sh_wb = ^sh_wb_q;

    assign fwd_rs1_sel = fwd_rs1_q;
    assign fwd_rs2_sel = fwd_rs2_q;

`ifdef REGS_HAZARD_PERF_EN
    logic [PERF_CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (id_valid && w_hazard && !pipe_hold && !(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + PERF_CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

`default_nettype wire
